// File: rtl/cmd_assembler.sv
// -----------------------------------------------------------------------------
// cmd_assembler
//   Assembles 16-bit commands from pairs of bytes delivered by a UART receiver.
//   The first byte is the high byte, the second the low byte. A completed
//   command is held on cmd with cmd_rdy until the consumer acknowledges it.
//
//   State table:
//     state   | meaning
//     WAIT_HI | idle, next received byte is the high byte
//     WAIT_LO | high byte held, next received byte completes the command
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_rdy       in   byte valid from the UART receiver
//   rx_data[7:0] in   received byte, valid while rx_rdy=1
//   clr_rx_rdy   out  byte-consumed pulse, high in the capture cycle
//   cmd[15:0]    out  assembled command {high, low}
//   cmd_rdy      out  a complete command is held on cmd
//   clr_cmd_rdy  in   consumer acknowledge for cmd_rdy
//   overrun      out  sticky: command completed while previous was unacked
//   timeout      out  one-cycle pulse when a partial command is discarded
//
// Build option:
//   CMD_TIMEOUT_EN  when defined, a partial command is dropped after
//                   TO_CYCLES idle cycles in WAIT_LO. When undefined, no
//                   counter exists, timeout is 0 and WAIT_LO waits forever.
// -----------------------------------------------------------------------------
module cmd_assembler #(
    parameter logic [15:0] TO_CYCLES = 16'd52000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        overrun_q, overrun_d;
    logic        complete;
    logic        expire;

`ifdef CMD_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    // A byte arriving in the expiry cycle takes priority, hence the !rx_rdy.
    assign expire = (state_q == WAIT_LO) && !rx_rdy && (cnt_q == (TO_CYCLES - 16'd1));

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = expire;
        if (state_q == WAIT_HI) begin
            // Held at zero while idle so WAIT_LO is always entered with a clear count.
            cnt_d = 16'd0;
        end else if (!rx_rdy) begin
            cnt_d = expire ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_to_cycles;

    assign unused_to_cycles = ^TO_CYCLES;
    assign expire           = 1'b0;
    assign timeout          = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_HI;
            hi_q      <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_HI: if (rx_rdy) state_d = WAIT_LO;
            WAIT_LO: if (rx_rdy || expire) state_d = WAIT_HI;
            default: state_d = WAIT_HI;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        clr_rx_rdy = rx_rdy && !rst;
        complete   = rx_rdy && (state_q == WAIT_LO);

        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        overrun_d = overrun_q;

        if ((state_q == WAIT_HI) && rx_rdy) begin
            hi_d = rx_data;
        end else if (expire) begin
            hi_d = 8'h00;
        end

        // A completion beats an acknowledge in the same cycle; overrun only
        // when the previous command was still pending and not being acked.
        if (complete) begin
            cmd_d     = {hi_q, rx_data};
            cmd_rdy_d = 1'b1;
            if (cmd_rdy_q && !clr_cmd_rdy) begin
                overrun_d = 1'b1;
            end
        end else if (clr_cmd_rdy) begin
            cmd_rdy_d = 1'b0;
        end
    end

    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_cmd_assembler.sv
module tb_cmd_assembler;

    localparam logic [15:0] TO = 16'd100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        overrun;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int clr_pulses = 0;
    int to_pulses = 0;

    // Reference model: a command is "pending" once a high byte is held;
    // idle counts whole idle cycles spent waiting for the low byte.
    bit          m_pend;
    logic [7:0]  m_hi;
    int          m_idle;
    logic [15:0] m_cmd;
    logic        m_rdy;
    logic        m_ovr;
    logic        m_to;

    cmd_assembler #(.TO_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic r, input logic v, input logic [7:0] d, input logic c);
        logic [15:0] newcmd;
        bit          done;
        bit          to_n;
        done = 0;
        to_n = 0;
        newcmd = 16'h0;
        if (r) begin
            m_pend = 0; m_hi = 8'h0; m_idle = 0;
            m_cmd = 16'h0; m_rdy = 0; m_ovr = 0; m_to = 0;
            return;
        end
        if (v) begin
            if (!m_pend) begin
                m_pend = 1; m_hi = d; m_idle = 0;
            end else begin
                done = 1; newcmd = {m_hi, d}; m_pend = 0;
            end
        end else if (m_pend) begin
`ifdef CMD_TIMEOUT_EN
            m_idle++;
            if (m_idle == int'(TO)) begin
                m_pend = 0;
                to_n = 1;
            end
`endif
        end
        if (done) begin
            if (m_rdy && !c) m_ovr = 1;
            m_cmd = newcmd;
            m_rdy = 1;
        end else if (c) begin
            m_rdy = 0;
        end
        m_to = to_n;
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic c);
        rst = r; rx_rdy = v; rx_data = d; clr_cmd_rdy = c;
        #1;
        chk("clr_rx_rdy", {15'h0, clr_rx_rdy}, {15'h0, v & ~r});
        if (clr_rx_rdy === 1'b1) clr_pulses++;
        model(r, v, d, c);
        @(posedge clk);
        #1;
        if (timeout === 1'b1) to_pulses++;
        chk("cmd", cmd, m_cmd);
        chk("cmd_rdy", {15'h0, cmd_rdy}, {15'h0, m_rdy});
        chk("overrun", {15'h0, overrun}, {15'h0, m_ovr});
        chk("timeout", {15'h0, timeout}, {15'h0, m_to});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'($urandom), 0);
    endtask

    task automatic send(input logic [7:0] d, input logic c);
        step(0, 1, d, c);
    endtask

    initial begin
        int gap;
        m_pend = 0; m_hi = 0; m_idle = 0; m_cmd = 0; m_rdy = 0; m_ovr = 0; m_to = 0;

        // Reset with bytes presented: must be ignored, clr_rx_rdy low
        for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 0);
        chk("reset_cmd", cmd, 16'h0000);

        // A5 / 3C spaced apart
`ifdef CMD_TIMEOUT_EN
        gap = 50;
`else
        gap = 2000;
`endif
        clr_pulses = 0;
        send(8'hA5, 0);
        idle(gap - 1);
        send(8'h3C, 0);
        chk("a53c_cmd", cmd, 16'hA53C);
        chk("a53c_rdy", {15'h0, cmd_rdy}, 16'h1);
        chk("a53c_clr_pulses", 16'(clr_pulses), 16'd2);
        step(0, 0, 8'h00, 1);
        chk("ack_clears", {15'h0, cmd_rdy}, 16'h0);
        chk("cmd_held", cmd, 16'hA53C);

        // Overrun
        send(8'h12, 0); send(8'h34, 0); idle(3);
        send(8'h56, 0); idle(2); send(8'h78, 0);
        chk("ovr_cmd", cmd, 16'h5678);
        chk("ovr_flag", {15'h0, overrun}, 16'h1);
        step(0, 0, 8'h00, 1); idle(5);
        chk("ovr_sticky", {15'h0, overrun}, 16'h1);

        // Completion coincident with acknowledge
        step(1, 0, 8'h00, 0);
        send(8'hDE, 0); send(8'hAD, 0);
        send(8'hBE, 0); send(8'hEF, 1);
        chk("setwins_rdy", {15'h0, cmd_rdy}, 16'h1);
        chk("setwins_ovr", {15'h0, overrun}, 16'h0);
        chk("setwins_cmd", cmd, 16'hBEEF);

        // Reset while waiting for the low byte
        to_pulses = 0;
        send(8'h77, 0); idle(2);
        step(1, 0, 8'h00, 0);
        send(8'h10, 0); send(8'h20, 0);
        chk("rst_lo_cmd", cmd, 16'h1020);
        chk("rst_lo_no_to", 16'(to_pulses), 16'd0);

`ifdef CMD_TIMEOUT_EN
        // Expiry after TO idle cycles, then fresh command
        to_pulses = 0;
        send(8'hFF, 0); idle(int'(TO));
        send(8'h01, 0); send(8'h02, 0);
        chk("to_pulses", 16'(to_pulses), 16'd1);
        chk("to_cmd", cmd, 16'h0102);
        // Byte arriving in the expiry cycle wins
        to_pulses = 0;
        send(8'hC3, 0); idle(int'(TO) - 1); send(8'h5A, 0);
        chk("to_edge_cmd", cmd, 16'hC35A);
        chk("to_edge_none", 16'(to_pulses), 16'd0);
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) == 0),
                 8'($urandom), ($urandom_range(0, 7) == 0));
        end
        // Occasional long gaps to exercise the idle path
        for (int i = 0; i < 3; i++) begin
            send(8'($urandom), 0);
            idle(int'($urandom_range(90, 110)));
            send(8'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
